// File: rtl/result_writeback.sv
// result_writeback: takes accumulator results over a valid/ready handshake and
// writes each one as little-endian bytes to consecutive memory addresses,
// starting at a programmable base. A one-cycle done pulse closes every vector
// of N_ROWS results.
//
// state   | meaning
// IDLE    | ready for the next result; config may load while no vector is open
// WRITE   | streaming bytes of acc_q to memory, one per accepted request
module result_writeback #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int N_ROWS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_vld,
  input  logic [ADDR_WIDTH-1:0] cfg_y_base,
  input  logic                  res_vld,
  output logic                  res_rdy,
  input  logic [ACC_WIDTH-1:0]  res_data,
  output logic                  w_req_vld,
  input  logic                  w_req_rdy,
  output logic [ADDR_WIDTH-1:0] w_req_addr,
  output logic [DATA_WIDTH-1:0] w_req_data,
  output logic                  done,
  output logic                  busy
);

  localparam int BYTES = ACC_WIDTH / DATA_WIDTH;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(N_ROWS - 1);

  logic [0:0]            state_q,    state_d;
  logic [RW-1:0]         row_cnt_q,  row_cnt_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [ACC_WIDTH-1:0]  acc_q,      acc_d;
  logic [ADDR_WIDTH-1:0] y_base_q,   y_base_d;
  logic                  done_q,     done_d;

  logic                  res_hs;
  logic [ADDR_WIDTH-1:0] row_off;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_byte;

  // res_rdy is held low while reset is asserted so no result slips in during abort
  assign res_rdy   = !rst && (state_q == S_IDLE);
  assign res_hs    = res_vld && res_rdy;
  assign busy      = (state_q != S_IDLE) || (row_cnt_q != '0);
  assign w_req_vld = (state_q == S_WRITE);
  assign done      = done_q;

  // Address arithmetic is truncated to ADDR_WIDTH, so it wraps past the top of memory
  assign row_off    = ADDR_WIDTH'(row_cnt_q) * ADDR_WIDTH'(BYTES);
  assign wr_addr    = y_base_q + row_off + ADDR_WIDTH'(byte_idx_q);
  assign wr_byte    = acc_q[int'(byte_idx_q) * DATA_WIDTH +: DATA_WIDTH];
  assign w_req_addr = w_req_vld ? wr_addr : '0;
  assign w_req_data = w_req_vld ? wr_byte : '0;

  // Next-state logic for sequencing, row/byte counters and base-address config
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    y_base_d   = y_base_q;
    done_d     = 1'b0;

    // A load in the same cycle as the first handshake of a vector lands before
    // the first byte is addressed, so the new base applies to that row.
    if (cfg_vld && !busy) begin
      y_base_d = cfg_y_base;
    end

    case (state_q)
      S_IDLE: begin
        if (res_hs) begin
          acc_d      = res_data;
          byte_idx_d = '0;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_req_rdy) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            state_d    = S_IDLE;
            if (row_cnt_q == LAST_ROW) begin
              row_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              row_cnt_d = row_cnt_q + RW'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset discards any partial vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      byte_idx_q <= '0;
      acc_q      <= '0;
      y_base_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      y_base_q   <= y_base_d;
      done_q     <= done_d;
    end
  end

endmodule
